// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding imem read at a time,
// holds the fetched word for decode and steers the next PC from the redirect controls.
package fetch_pkg;
   localparam int         SEL_PC_WIDTH = 2;
   localparam logic [1:0] SEL_PC_ADD4  = 2'd0;
   localparam logic [1:0] SEL_PC_JAL   = 2'd1;
   localparam logic [1:0] SEL_PC_JALR  = 2'd2;
endpackage

module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    imem_req_valid,
   input  logic                    imem_req_ready,
   output logic [31:0]             imem_req_addr,
   input  logic                    imem_rsp_valid,
   input  logic [31:0]             imem_rsp_data,
   output logic [31:0]             code,
   output logic [31:0]             code_pc,
   output logic                    code_valid,
   input  logic                    decode_ready,
   input  logic [SEL_PC_WIDTH-1:0] pc_sel,
   input  logic [31:0]             imm,
   input  logic [31:0]             rs1_data,
   input  logic                    br_taken,
   output logic [63:0]             instret,
   output logic                    fetch_err
);

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic [31:0] jalr_sum;

   assign imem_req_addr = pc;

   // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
   always_comb begin
      jalr_sum = rs1_data + imm;
      next_pc  = code_pc + 32'd4;
      if (pc_sel == SEL_PC_JALR)
         next_pc = jalr_sum & ~32'h1;
      else if (pc_sel == SEL_PC_JAL)
         next_pc = code_pc + imm;
      else if (code[6:0] == OPC_BRANCH && br_taken)
         next_pc = code_pc + imm;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         pc             <= RESET_PC;
         imem_req_valid <= 1'b0;
         code           <= 32'h0;
         code_pc        <= 32'h0;
         code_valid     <= 1'b0;
         instret        <= 64'h0;
         fetch_err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               imem_req_valid <= 1'b1;
               state          <= REQ;
            end
            REQ: begin
               if (imem_req_ready) begin
                  imem_req_valid <= 1'b0;
                  state          <= WAIT;
               end
            end
            WAIT: begin
               if (imem_rsp_valid) begin
                  code       <= imem_rsp_data;
                  code_pc    <= pc;
                  code_valid <= 1'b1;
                  state      <= HOLD;
               end
            end
            HOLD: begin
               if (decode_ready) begin
                  code_valid <= 1'b0;
                  pc         <= next_pc;
                  instret    <= instret + 64'd1;
                  // A misaligned target still retires and lands in pc, then fetch stops.
                  if (next_pc[1:0] != 2'b00) begin
                     fetch_err <= 1'b1;
                     state     <= ERR;
                  end else begin
                     imem_req_valid <= 1'b1;
                     state          <= REQ;
                  end
               end
            end
            ERR: begin
               imem_req_valid <= 1'b0;
               code_valid     <= 1'b0;
               fetch_err      <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, backpressure, a table of redirect
// vectors reached by jumping to each test PC, misalignment halt and async reset mid-WAIT.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] BEQ    = 32'h0000_0063;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] code;
   logic [31:0] code_pc;
   logic        code_valid;
   logic        decode_ready;
   logic [1:0]  pc_sel;
   logic [31:0] imm;
   logic [31:0] rs1_data;
   logic        br_taken;
   logic [63:0] instret;
   logic        fetch_err;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .code(code), .code_pc(code_pc), .code_valid(code_valid),
      .decode_ready(decode_ready), .pc_sel(pc_sel), .imm(imm),
      .rs1_data(rs1_data), .br_taken(br_taken),
      .instret(instret), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   // One-cycle-latency memory model; rsp_force lets a sequence inject a stray response.
   logic [31:0] imem [logic [31:0]];
   logic        mem_auto   = 1'b0;
   logic        rsp_pend   = 1'b0;
   logic [31:0] rsp_data_q = 32'h0;
   logic        rsp_force  = 1'b0;
   logic [31:0] force_data = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (imem.exists(a)) return imem[a];
      return NOP;
   endfunction

   always @(posedge clk) begin
      rsp_pend   <= mem_auto && imem_req_valid && imem_req_ready;
      rsp_data_q <= mem_word(imem_req_addr);
   end

   assign imem_rsp_valid = rsp_pend | rsp_force;
   assign imem_rsp_data  = rsp_force ? force_data : rsp_data_q;

   int tests  = 0;
   int failed = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " req_valid"},  imem_req_valid, 0);
      check({tag, " req_addr"},   imem_req_addr, RST_PC);
      check({tag, " code"},       code, 0);
      check({tag, " code_pc"},    code_pc, 0);
      check({tag, " code_valid"}, code_valid, 0);
      check({tag, " instret"},    instret, 0);
      check({tag, " fetch_err"},  fetch_err, 0);
   endtask

   task automatic wait_hold(input string name);
      int n = 0;
      while (!code_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({name, " reached HOLD"}, code_valid, 1);
   endtask

   // Called at a negedge in HOLD; retires one instruction on the next rising edge.
   task automatic accept(input logic [1:0] sel, input logic [31:0] im,
                         input logic [31:0] rs, input logic br);
      pc_sel = sel; imm = im; rs1_data = rs; br_taken = br; decode_ready = 1'b1;
      @(posedge clk);
      #1;
      decode_ready = 1'b0; pc_sel = SEL_PC_ADD4; imm = 32'h0; rs1_data = 32'h0; br_taken = 1'b0;
   endtask

   typedef struct {
      string       name;
      logic [31:0] code;
      logic [31:0] pc;
      logic [1:0]  sel;
      logic [31:0] imm;
      logic [31:0] rs1;
      logic        br;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] exp_instret;

      vecs[0] = '{"jal_back",      NOP, 32'h200, SEL_PC_JAL,  32'hFFFF_FFF0, 32'h0,    1'b0, 32'h0000_01F0, 1'b0};
      vecs[1] = '{"jalr_clr_bit0", NOP, 32'h200, SEL_PC_JALR, 32'h4,         32'h1001, 1'b0, 32'h0000_1004, 1'b0};
      vecs[2] = '{"beq_taken",     BEQ, 32'h300, SEL_PC_ADD4, 32'h20,        32'h0,    1'b1, 32'h0000_0320, 1'b0};
      vecs[3] = '{"beq_not_taken", BEQ, 32'h300, SEL_PC_ADD4, 32'h20,        32'h0,    1'b0, 32'h0000_0304, 1'b0};
      vecs[4] = '{"nonbr_ignore",  NOP, 32'h400, SEL_PC_ADD4, 32'h20,        32'h0,    1'b1, 32'h0000_0404, 1'b0};
      vecs[5] = '{"jalr_over_br",  BEQ, 32'h500, SEL_PC_JALR, 32'h0,         32'h800,  1'b1, 32'h0000_0800, 1'b0};
      vecs[6] = '{"add4_wrap",     NOP, 32'hFFFF_FFFC, SEL_PC_ADD4, 32'h0,   32'h0,    1'b0, 32'h0000_0000, 1'b0};
      vecs[7] = '{"jalr_misalign", NOP, 32'h600, SEL_PC_JALR, 32'h2,         32'h100,  1'b0, 32'h0000_0102, 1'b1};

      rst_n = 1'b0; imem_req_ready = 1'b0; decode_ready = 1'b0;
      pc_sel = SEL_PC_ADD4; imm = 32'h0; rs1_data = 32'h0; br_taken = 1'b0;

      @(negedge clk);
      check_reset_values("reset");

      // Sequential NOP stream: REQ, WAIT, HOLD repeating
      @(negedge clk);
      imem_req_ready = 1'b1; decode_ready = 1'b1; mem_auto = 1'b1; rst_n = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check($sformatf("seq code_valid c%0d", i), code_valid, (i % 3) == 2);
         if (i % 3 == 0) begin
            check($sformatf("seq req_valid c%0d", i), imem_req_valid, 1);
            check($sformatf("seq req_addr c%0d", i), imem_req_addr, RST_PC + 32'(4 * (i / 3)));
         end
         if (i % 3 == 2) begin
            check($sformatf("seq code_pc c%0d", i), code_pc, RST_PC + 32'(4 * (i / 3)));
            check($sformatf("seq code c%0d", i), code, NOP);
         end
      end
      @(posedge clk);
      #1;
      decode_ready = 1'b0; imem_req_ready = 1'b0;
      check("seq instret", instret, 3);

      // Request backpressure
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("req_bp valid c%0d", i), imem_req_valid, 1);
         check($sformatf("req_bp addr c%0d", i), imem_req_addr, 32'h10C);
      end
      imem_req_ready = 1'b1;
      wait_hold("dec_bp");

      // Decode backpressure
      for (int i = 0; i < 5; i++) begin
         check($sformatf("dec_bp code_valid c%0d", i), code_valid, 1);
         check($sformatf("dec_bp code_pc c%0d", i), code_pc, 32'h10C);
         check($sformatf("dec_bp code c%0d", i), code, NOP);
         check($sformatf("dec_bp instret c%0d", i), instret, 3);
         @(negedge clk);
      end

      // Redirect table: jump to each vector's PC, then apply its controls
      exp_instret = 64'd3;
      foreach (vecs[k]) begin
         imem[vecs[k].pc] = vecs[k].code;
         wait_hold({vecs[k].name, " pre"});
         accept(SEL_PC_JALR, 32'h0, vecs[k].pc, 1'b0);
         exp_instret++;
         check({vecs[k].name, " jump addr"}, imem_req_addr, vecs[k].pc);
         @(negedge clk);
         wait_hold(vecs[k].name);
         check({vecs[k].name, " code_pc"}, code_pc, vecs[k].pc);
         check({vecs[k].name, " code"}, code, vecs[k].code);
         accept(vecs[k].sel, vecs[k].imm, vecs[k].rs1, vecs[k].br);
         exp_instret++;
         check({vecs[k].name, " next addr"}, imem_req_addr, vecs[k].exp);
         check({vecs[k].name, " fetch_err"}, fetch_err, vecs[k].err);
         check({vecs[k].name, " instret"}, instret, exp_instret);
         @(negedge clk);
         check({vecs[k].name, " req_valid"}, imem_req_valid, !vecs[k].err);
      end

      // ERR is sticky and quiet
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("err req_valid c%0d", i), imem_req_valid, 0);
         check($sformatf("err code_valid c%0d", i), code_valid, 0);
         check($sformatf("err fetch_err c%0d", i), fetch_err, 1);
      end

      // Async reset while waiting for a response
      @(negedge clk);
      rst_n = 1'b0; mem_auto = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("wait_rst in REQ", imem_req_valid, 1);
      @(negedge clk);
      check("wait_rst in WAIT", imem_req_valid, 0);
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      rsp_force = 1'b1; force_data = 32'hDEAD_BEEF;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      rsp_force = 1'b0;
      check("late_rsp code_valid", code_valid, 0);
      check("late_rsp code", code, 0);
      check("restart req_valid", imem_req_valid, 1);
      check("restart req_addr", imem_req_addr, RST_PC);
      mem_auto = 1'b1;
      wait_hold("restart");
      check("restart code", code, NOP);
      check("restart code_pc", code_pc, RST_PC);
      check("restart instret", instret, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that produces the `code` word consumed by the decoder. It holds the architectural PC and issues single-outstanding word reads to instruction memory over a valid/ready request and valid response interface. It presents each fetched instruction with its PC to decode, then computes the next PC from the decoder/ALU redirect controls when decode accepts the instruction. It also keeps the retired-instruction counter for the CSR file.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word address of request (equals pc).
- imem_rsp_valid  in  1  read data valid; ≥1 cycle after request acceptance.
- imem_rsp_data  in  32  instruction word.
- code  out  32  instruction to decoder.
- code_pc  out  32  PC of `code`.
- code_valid  out  1  `code`/`code_pc` valid.
- decode_ready  in  1  decode/execute consumes instruction this cycle.
- pc_sel  in  `SEL_PC_WIDTH`  from decode: `SEL_PC_ADD4`, `SEL_PC_JAL`, `SEL_PC_JALR`.
- imm  in  32  decoded immediate for current `code`.
- rs1_data  in  32  rs1 value for current `code`.
- br_taken  in  1  ALU compare result for current BRANCH.
- instret  out  64  retired instruction count.
- fetch_err  out  1  misaligned next-PC detected; fetch halted.

## Operation
- States: IDLE, REQ, WAIT, HOLD, ERR. Reset state IDLE.
- IDLE: unconditionally → REQ next edge.
- REQ: imem_req_valid=1, imem_req_addr=pc. On valid&ready → WAIT.
- WAIT: on imem_rsp_valid capture imem_rsp_data into `code`, pc into `code_pc`; → HOLD.
- HOLD: code_valid=1. On decode_ready: compute next_pc, instret+=1, pc←next_pc; → REQ, or → ERR if next_pc[1:0]≠0 (pc still updated to the bad value, instret still incremented).
- ERR: fetch_err=1, all other handshake outputs 0; exit only by reset.
- next_pc priority: pc_sel==`SEL_PC_JALR` → (rs1_data+imm)&~32'h1; pc_sel==`SEL_PC_JAL` → code_pc+imm; code[6:0]==7'b1100011 && br_taken → code_pc+imm; else code_pc+4.
- All adds modulo 2^32 (wrap, no flag). instret wraps 2^64−1 → 0.
- imem_rsp_valid outside WAIT ignored (no capture). imem_req_ready outside REQ ignored.
- pc_sel/imm/rs1_data/br_taken sampled only in HOLD with decode_ready.

## Timing
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, code=0, code_pc=0, code_valid=0, instret=0, fetch_err=0; pc=RESET_PC.
- Reset is asynchronous: assertion mid-transaction immediately forces IDLE and reset values; any in-flight response is dropped (memory side owns its own reset).
- First request: imem_req_valid rises at the first rising edge after rst_n deasserts (IDLE→REQ).
- imem_req_addr and imem_req_valid held stable while valid && !ready.
- Throughput with ready=1 and 1-cycle memory: one instruction per 3 cycles (REQ, WAIT, HOLD) when decode_ready=1.
- code/code_pc stable throughout HOLD; code_valid falls the edge after decode_ready.
- instret updated on the same edge that leaves HOLD; visible next cycle.

## Test plan
- Reset/sequential: RESET_PC=0x100, ready=1, 1-cycle memory of NOPs (0x00000013), decode_ready=1 → requests at 0x100, 0x104, 0x108; code_valid every 3rd cycle; instret=3 after third accept.
- Backpressure: hold imem_req_ready=0 for 4 cycles then 1; hold decode_ready=0 for 5 cycles in HOLD → addr, code, code_pc unchanged throughout; no extra instret increments.
- JAL/JALR: code_pc=0x200, pc_sel=JAL, imm=0xFFFF_FFF0 → next addr 0x1F0; pc_sel=JALR, rs1_data=0x1001, imm=0x4 → next addr 0x1004 (bit0 cleared).
- Branch: code=BEQ (opcode 1100011), code_pc=0x300, imm=0x20: br_taken=1 → 0x320; br_taken=0 → 0x304.
- Misalign/wrap: JALR to 0x0000_0102 → fetch_err=1 next cycle, imem_req_valid stays 0; separately code_pc=0xFFFF_FFFC ADD4 → next addr 0x0000_0000.
- Async reset mid-WAIT: assert rst_n=0 between request accept and response → outputs return to reset values immediately; late imem_rsp_valid ignored; fetch restarts at RESET_PC.
